// File: rtl/bcd_7seg_scan_driver.sv
// rtl/bcd_7seg_scan_driver.sv - time-multiplexed BCD to 7-segment scan driver
module bcd_7seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int ACTIVE_LOW_SEG = 0,
    parameter int ACTIVE_LOW_AN  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    // Polarity masks: XOR the active-high form with these to get pin levels.
    localparam logic                  SEG_INV  = (ACTIVE_LOW_SEG != 0);
    localparam logic                  AN_INV   = (ACTIVE_LOW_AN != 0);
    localparam logic [6:0]            SEG_MASK = {7{SEG_INV}};
    localparam logic [NUM_DIGITS-1:0] AN_MASK  = {NUM_DIGITS{AN_INV}};

    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [PW-1:0]           pre_cnt;
    logic [IW-1:0]           idx;
    logic                    pre_tc;

    logic [3:0]              digit_sel;
    logic                    dp_sel;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic                    upper_nonzero;
    logic                    lz_blank;
    logic [6:0]              seg_act;

    // Active-high segment pattern {a..g}; codes above 9 are blank.
    function automatic logic [6:0] decode_bcd(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'd0:    pattern = 7'b1111110;
            4'd1:    pattern = 7'b0110000;
            4'd2:    pattern = 7'b1101101;
            4'd3:    pattern = 7'b1111001;
            4'd4:    pattern = 7'b0110011;
            4'd5:    pattern = 7'b1011011;
            4'd6:    pattern = 7'b1011111;
            4'd7:    pattern = 7'b1110000;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1111011;
            default: pattern = 7'b0000000;
        endcase
        return pattern;
    endfunction

    assign pre_tc = (pre_cnt == PRE_LAST);

    // Shadow registers hold the displayed value between load strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
        end else if (load) begin
            shadow_bcd <= bcd_in;
            shadow_dp  <= dp_in;
        end
    end

    // Dwell prescaler and digit index; index advances once per dwell period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (pre_tc) begin
            pre_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
        end else begin
            pre_cnt <= pre_cnt + PRE_ONE;
        end
    end

    // Select the current digit and decide whether it is a suppressed leading zero.
    always_comb begin
        digit_sel     = 4'd0;
        dp_sel        = 1'b0;
        an_sel        = '0;
        upper_nonzero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) begin
                digit_sel = shadow_bcd[4*i +: 4];
                dp_sel    = shadow_dp[i];
                an_sel[i] = 1'b1;
            end
            if ((IW'(i) >= idx) && (shadow_bcd[4*i +: 4] != 4'd0)) begin
                upper_nonzero = 1'b1;
            end
        end
        lz_blank = blank_lz && (idx != '0) && !upper_nonzero;
        seg_act  = lz_blank ? 7'b0000000 : decode_bcd(digit_sel);
    end

    // Registered pin drivers and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_MASK;
            dp         <= SEG_INV;
            an         <= AN_MASK;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_act ^ SEG_MASK;
            dp         <= dp_sel ^ SEG_INV;
            an         <= an_sel ^ AN_MASK;
            frame_done <= pre_tc && (idx == IDX_LAST);
        end
    end

endmodule
